// File: rtl/reaction_seq_if.sv
// Handshake/display bundle between the reaction-timer sequencer and its surroundings.
interface reaction_seq_if #(
  parameter int unsigned NUM_LEDS = 10,
  parameter int unsigned CNT_W    = 16
);
  logic                tick;
  logic                trigger;
  logic                time_out;
  logic                react;
  logic                en_lfsr;
  logic                start_delay;
  logic                enable;
  logic                clr;
  logic [NUM_LEDS-1:0] ledr;
  logic [CNT_W-1:0]    rt_count;
  logic                rt_valid;
  logic                rt_miss;
  logic                fault;

  modport master (
    output tick, trigger, time_out, react,
    input  en_lfsr, start_delay, enable, clr, ledr, rt_count, rt_valid, rt_miss, fault
  );

  modport slave (
    input  tick, trigger, time_out, react,
    output en_lfsr, start_delay, enable, clr, ledr, rt_count, rt_valid, rt_miss, fault
  );
endinterface

// File: rtl/reaction_seq.sv
// Reaction-timer sequencer: LED bar fill, random-delay handshake, GO phase and reaction measurement.
// Optional false-start detection (FAULT state) is enabled by defining FALSE_START_DET_EN.
module reaction_seq #(
  parameter int unsigned NUM_LEDS = 10,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_RT   = 9999
) (
  input  logic           clk,
  input  logic           reset_n,
  reaction_seq_if.slave  bus
);

  localparam int unsigned          LC_W     = $clog2(NUM_LEDS + 1);
  localparam logic [NUM_LEDS-1:0]  LED_ALL  = '1;
  localparam logic [NUM_LEDS-1:0]  LED_MSB  = NUM_LEDS'(1) << (NUM_LEDS - 1);
  localparam logic [LC_W-1:0]      LED_LAST = LC_W'(NUM_LEDS);
  localparam logic [CNT_W-1:0]     RT_LAST  = CNT_W'(MAX_RT - 1);
  localparam logic [CNT_W-1:0]     RT_MAX   = CNT_W'(MAX_RT);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_DELAY, S_GO, S_DONE, S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [LC_W-1:0]     led_cnt_q, led_cnt_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic [CNT_W-1:0]    rt_count_q, rt_count_d;
  logic                en_lfsr_q, en_lfsr_d;
  logic                start_delay_q, start_delay_d;
  logic                enable_q, enable_d;
  logic                clr_q, clr_d;
  logic                rt_valid_q, rt_valid_d;
  logic                rt_miss_q, rt_miss_d;
  logic                start_c;
`ifdef FALSE_START_DET_EN
  logic                fault_q, fault_d;
`endif

  assign start_c = bus.trigger && bus.tick;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    led_cnt_d     = led_cnt_q;
    ledr_d        = ledr_q;
    rt_count_d    = rt_count_q;
    en_lfsr_d     = en_lfsr_q;
    start_delay_d = 1'b0;
    enable_d      = enable_q;
    clr_d         = 1'b0;
    rt_valid_d    = rt_valid_q;
    rt_miss_d     = rt_miss_q;
`ifdef FALSE_START_DET_EN
    fault_d       = fault_q;
`endif

    case (state_q)
      S_IDLE: begin
        ledr_d = '0;
        if (start_c) state_d = S_FILL;
      end
      S_FILL: begin
        en_lfsr_d = 1'b1;
        if (bus.tick) begin
          if (led_cnt_q < LED_LAST) begin
            led_cnt_d = led_cnt_q + LC_W'(1);
            ledr_d    = (ledr_q >> 1) | LED_MSB;
          end else begin
            state_d       = S_DELAY;
            en_lfsr_d     = 1'b0;
            start_delay_d = 1'b1;
          end
        end
      end
      S_DELAY: begin
        ledr_d = LED_ALL;
        if (bus.time_out) begin
          state_d    = S_GO;
          ledr_d     = '0;
          enable_d   = 1'b1;
          rt_count_d = '0;
          rt_valid_d = 1'b0;
          rt_miss_d  = 1'b0;
        end
      end
      S_GO: begin
        // A press wins over a coincident tick so the reported time is not overstated.
        if (bus.react) begin
          state_d    = S_DONE;
          rt_valid_d = 1'b1;
          enable_d   = 1'b0;
        end else if (bus.tick) begin
          if (rt_count_q >= RT_LAST) begin
            state_d    = S_DONE;
            rt_count_d = RT_MAX;
            rt_miss_d  = 1'b1;
            rt_valid_d = 1'b0;
            enable_d   = 1'b0;
          end else begin
            rt_count_d = rt_count_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        ledr_d = '0;
        if (start_c) state_d = S_FILL;
      end
`ifdef FALSE_START_DET_EN
      S_FAULT: begin
        if (start_c) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          ledr_d  = '0;
        end else if (bus.tick) begin
          ledr_d = ~ledr_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Common round-start actions for entry into FILL from IDLE or DONE
    if (state_d == S_FILL && state_q != S_FILL) begin
      clr_d      = 1'b1;
      led_cnt_d  = LC_W'(1);
      ledr_d     = LED_MSB;
      en_lfsr_d  = 1'b1;
      rt_valid_d = 1'b0;
      rt_miss_d  = 1'b0;
    end

`ifdef FALSE_START_DET_EN
    if (bus.react && (state_q == S_FILL || state_q == S_DELAY)) begin
      state_d       = S_FAULT;
      fault_d       = 1'b1;
      en_lfsr_d     = 1'b0;
      start_delay_d = 1'b0;
      ledr_d        = LED_ALL;
      rt_valid_d    = 1'b0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      led_cnt_q     <= '0;
      ledr_q        <= '0;
      rt_count_q    <= '0;
      en_lfsr_q     <= 1'b0;
      start_delay_q <= 1'b0;
      enable_q      <= 1'b0;
      clr_q         <= 1'b0;
      rt_valid_q    <= 1'b0;
      rt_miss_q     <= 1'b0;
`ifdef FALSE_START_DET_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      led_cnt_q     <= led_cnt_d;
      ledr_q        <= ledr_d;
      rt_count_q    <= rt_count_d;
      en_lfsr_q     <= en_lfsr_d;
      start_delay_q <= start_delay_d;
      enable_q      <= enable_d;
      clr_q         <= clr_d;
      rt_valid_q    <= rt_valid_d;
      rt_miss_q     <= rt_miss_d;
`ifdef FALSE_START_DET_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign bus.en_lfsr     = en_lfsr_q;
  assign bus.start_delay = start_delay_q;
  assign bus.enable      = enable_q;
  assign bus.clr         = clr_q;
  assign bus.ledr        = ledr_q;
  assign bus.rt_count    = rt_count_q;
  assign bus.rt_valid    = rt_valid_q;
  assign bus.rt_miss     = rt_miss_q;
`ifdef FALSE_START_DET_EN
  assign bus.fault       = fault_q;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule
